// File: rtl/result_stream_ctrl_if.sv
// AXI-Stream result beat bus between the result sequencer and the DMA write path.
// The sequencer uses the master modport, the DMA side uses the slave modport.
interface result_stream_ctrl_if;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;

   modport master (
      output m_axis_tdata,
      output m_axis_tvalid,
      output m_axis_tlast,
      input  m_axis_tready
   );

   modport slave (
      input  m_axis_tdata,
      input  m_axis_tvalid,
      input  m_axis_tlast,
      output m_axis_tready
   );
endinterface

// File: rtl/result_stream_ctrl.sv
// Result path sequencer: accumulate -> sign wait -> latch -> drain as 64-bit beats -> clear.
// Drives store/stream_v/counter_clr of the sign-bit counter bank and streams each latched sign vector.
module result_stream_ctrl #(
   parameter int DIM      = 1023,
   parameter int SIGN_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [29:0]          item_num,
   input  logic [15:0]          result_num,
   input  logic                 core_valid,
   output logic                 core_ready,
   output logic                 store,
   output logic                 counter_clr,
   output logic                 stream_v,
   input  logic [DIM:0]         stream_d,
   result_stream_ctrl_if.master m_axis,
   output logic                 busy,
   output logic                 done
);
   localparam int BEATS = (DIM + 1) / 64;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WW    = $clog2(SIGN_LAT + 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
   localparam logic [WW-1:0] WAIT_LOAD = WW'(SIGN_LAT);
   localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACCUM = 3'd1,
      S_WAIT  = 3'd2,
      S_LATCH = 3'd3,
      S_SEND  = 3'd4,
      S_CLEAR = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [29:0]     rem_items_q, rem_items_d;
   logic [29:0]     item_num_q, item_num_d;
   logic [15:0]     rem_results_q, rem_results_d;
   logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic            done_q, done_d;
   logic            counter_clr_q, counter_clr_d;
   logic            stream_v_q, stream_v_d;
   logic            store_s;
   logic            hs_s;
   logic [63:0]     words_s [BEATS];

   assign core_ready = (state_q == S_ACCUM);
   assign store_s    = core_valid & core_ready;
   assign store      = store_s;
   assign hs_s       = (state_q == S_SEND) & m_axis.m_axis_tready;

   // Split the latched sign vector into beat-sized words; beat 0 carries the LSBs.
   always_comb begin
      for (int i = 0; i < BEATS; i++) begin
         words_s[i] = stream_d[64*i +: 64];
      end
   end

   assign m_axis.m_axis_tdata  = words_s[beat_q];
   assign m_axis.m_axis_tvalid = (state_q == S_SEND);
   assign m_axis.m_axis_tlast  = (state_q == S_SEND) & (beat_q == BEAT_LAST) & (rem_results_q == 16'd1);
   assign busy                 = (state_q != S_IDLE);
   assign done                 = done_q;
   assign counter_clr          = counter_clr_q;
   assign stream_v             = stream_v_q;

   // Next-state and counter update for the accumulate/sign/drain/clear cycle.
   always_comb begin
      state_d       = state_q;
      rem_items_d   = rem_items_q;
      item_num_d    = item_num_q;
      rem_results_d = rem_results_q;
      wait_cnt_d    = wait_cnt_q;
      beat_d        = beat_q;
      done_d        = 1'b0;
      counter_clr_d = 1'b0;
      stream_v_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               rem_items_d   = item_num;
               item_num_d    = item_num;
               rem_results_d = result_num;
               if ((item_num == 30'd0) || (result_num == 16'd0)) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_ACCUM;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCUM: begin
            if (store_s) begin
               rem_items_d = rem_items_q - 30'd1;
               if (rem_items_q == 30'd1) begin
                  wait_cnt_d = WAIT_LOAD;
                  state_d    = S_WAIT;
               end else begin
                  state_d = S_ACCUM;
               end
            end else begin
               state_d = S_ACCUM;
            end
         end
         // stream_v is raised for the cycle in which the count sits at zero.
         S_WAIT: begin
            if (wait_cnt_q == '0) begin
               state_d = S_LATCH;
            end else begin
               wait_cnt_d = wait_cnt_q - WAIT_ONE;
               stream_v_d = (wait_cnt_q == WAIT_ONE);
            end
         end
         S_LATCH: begin
            beat_d  = '0;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (hs_s) begin
               if (beat_q == BEAT_LAST) begin
                  beat_d        = '0;
                  rem_results_d = rem_results_q - 16'd1;
                  if (rem_results_q == 16'd1) begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     counter_clr_d = 1'b1;
                     state_d       = S_CLEAR;
                  end
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end else begin
               state_d = S_SEND;
            end
         end
         S_CLEAR: begin
            rem_items_d = item_num_q;
            state_d     = S_ACCUM;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         rem_items_q   <= 30'd0;
         item_num_q    <= 30'd0;
         rem_results_q <= 16'd0;
         wait_cnt_q    <= '0;
         beat_q        <= '0;
         done_q        <= 1'b0;
         counter_clr_q <= 1'b0;
         stream_v_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         rem_items_q   <= rem_items_d;
         item_num_q    <= item_num_d;
         rem_results_q <= rem_results_d;
         wait_cnt_q    <= wait_cnt_d;
         beat_q        <= beat_d;
         done_q        <= done_d;
         counter_clr_q <= counter_clr_d;
         stream_v_q    <= stream_v_d;
      end
   end
endmodule

// File: tb/tb_result_stream_ctrl.sv
// Directed bench for result_stream_ctrl with a behavioural counter-bank model
// and a negedge monitor that scores every beat against a hand-built pattern.
module tb_result_stream_ctrl;
   localparam int DIM   = 1023;
   localparam int BEATS = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [29:0]    item_num;
   logic [15:0]    result_num;
   logic           core_valid;
   logic           core_ready, store, counter_clr, stream_v, busy, done;
   logic [DIM:0]   stream_d = '0;

   result_stream_ctrl_if m_if();

   result_stream_ctrl #(.DIM(DIM), .SIGN_LAT(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .item_num    (item_num),
      .result_num  (result_num),
      .core_valid  (core_valid),
      .core_ready  (core_ready),
      .store       (store),
      .counter_clr (counter_clr),
      .stream_v    (stream_v),
      .stream_d    (stream_d),
      .m_axis      (m_if),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   int cyc = 0;
   int bank_idx = 0;
   int n_store = 0, n_sv = 0, n_clr = 0, n_hs = 0, n_last = 0, n_done = 0;
   int hs_k = 0, res_in_job = 0, job_res = 1;
   int last_store_cyc = 0, sv_cyc = 0, last_hs_cyc = 0;
   bit stall_prev = 1'b0, prev_tvalid = 1'b0, prev_last = 1'b0;
   logic [63:0] prev_data = 64'd0;

   function automatic logic [63:0] word_of(input int r, input int k);
      return {r[7:0], k[7:0], 16'hA5C3, 32'hDEAD_BEEF ^ 32'(r * 97 + k * 13)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Counter-bank model: each stream_v latches the next known pattern.
   always @(posedge clk) begin
      if (rst) begin
         stream_d <= '0;
      end else if (stream_v) begin
         for (int k = 0; k < BEATS; k++) stream_d[64*k +: 64] <= word_of(bank_idx, k);
         bank_idx <= bank_idx + 1;
      end
   end

   // Monitor: sampled mid-cycle, scores every handshake and strobe.
   always @(negedge clk) begin
      if (rst) begin
         hs_k = 0; res_in_job = 0; stall_prev = 1'b0; prev_tvalid = 1'b0;
      end else begin
         if (start && !busy) begin hs_k = 0; res_in_job = 0; end
         if (!core_ready) chk("store_gate", 64'(store), 64'd0);
         if (store) begin n_store++; last_store_cyc = cyc; end
         if (stream_v) begin
            n_sv++; sv_cyc = cyc;
            chk("sv_latency", 64'(cyc - last_store_cyc), 64'd2);
            chk("sv_not_in_send", 64'(m_if.m_axis_tvalid), 64'd0);
         end
         if (counter_clr) begin
            n_clr++;
            chk("clr_after_beat15", 64'(hs_k), 64'd0);
            chk("clr_after_result", 64'(res_in_job > 0), 64'd1);
            chk("clr_not_accum", 64'(core_ready), 64'd0);
         end
         if (m_if.m_axis_tvalid && !prev_tvalid) chk("tvalid_latency", 64'(cyc - sv_cyc), 64'd2);
         if (stall_prev) begin
            chk("hold_valid", 64'(m_if.m_axis_tvalid), 64'd1);
            chk("hold_data", m_if.m_axis_tdata, prev_data);
            chk("hold_last", 64'(m_if.m_axis_tlast), 64'(prev_last));
         end
         if (m_if.m_axis_tvalid && m_if.m_axis_tready) begin
            n_hs++; last_hs_cyc = cyc;
            chk("beat_data", m_if.m_axis_tdata, word_of(bank_idx - 1, hs_k));
            chk("beat_last", 64'(m_if.m_axis_tlast), 64'((hs_k == BEATS - 1) && (res_in_job == job_res - 1)));
            if (m_if.m_axis_tlast) n_last++;
            hs_k++;
            if (hs_k == BEATS) begin hs_k = 0; res_in_job++; end
         end
         stall_prev  = m_if.m_axis_tvalid && !m_if.m_axis_tready;
         prev_data   = m_if.m_axis_tdata;
         prev_last   = m_if.m_axis_tlast;
         prev_tvalid = m_if.m_axis_tvalid;
         if (done) n_done++;
      end
   end

   task automatic pulse_start(input logic [29:0] it, input logic [15:0] rs);
      item_num = it; result_num = rs; job_res = int'(rs);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input bit beats, input bit bp);
      logic [3:0] pat;
      bit seen;
      pat  = 4'b1001;
      seen = 1'b0;
      for (int k = 0; k < bound; k++) begin
         if (done) begin seen = 1'b1; break; end
         m_if.m_axis_tready = bp ? pat[k % 4] : 1'b1;
         tick();
      end
      chk("done_seen", 64'(seen), 64'd1);
      if (seen && beats) chk("done_after_last_hs", 64'(cyc - last_hs_cyc), 64'd1);
      m_if.m_axis_tready = 1'b1;
      tick();
      chk("done_pulse", 64'(done), 64'd0);
   endtask

   int s_store, s_sv, s_clr, s_hs, s_last, s_done, seen_b;
   logic [5:0] gpat;

   task automatic snap();
      s_store = n_store; s_sv = n_sv; s_clr = n_clr; s_hs = n_hs; s_last = n_last; s_done = n_done;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; item_num = 30'd0; result_num = 16'd0; core_valid = 1'b0;
      m_if.m_axis_tready = 1'b0;
      repeat (3) tick();
      chk("rst_core_ready", 64'(core_ready), 64'd0);
      chk("rst_store", 64'(store), 64'd0);
      chk("rst_counter_clr", 64'(counter_clr), 64'd0);
      chk("rst_stream_v", 64'(stream_v), 64'd0);
      chk("rst_tvalid", 64'(m_if.m_axis_tvalid), 64'd0);
      chk("rst_tlast", 64'(m_if.m_axis_tlast), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      rst = 1'b0;
      tick();

      // Single job, core_valid tied high, full tready.
      snap(); core_valid = 1'b1; m_if.m_axis_tready = 1'b1;
      pulse_start(30'd3, 16'd1);
      chk("a_busy", 64'(busy), 64'd1);
      wait_done(200, 1'b1, 1'b0);
      chk("a_stores", 64'(n_store - s_store), 64'd3);
      chk("a_stream_v", 64'(n_sv - s_sv), 64'd1);
      chk("a_beats", 64'(n_hs - s_hs), 64'd16);
      chk("a_tlast", 64'(n_last - s_last), 64'd1);
      chk("a_clr", 64'(n_clr - s_clr), 64'd0);
      chk("a_done", 64'(n_done - s_done), 64'd1);
      chk("a_idle", 64'(busy), 64'd0);

      // Backpressure with tready 1,0,0,1.
      snap();
      pulse_start(30'd3, 16'd1);
      wait_done(400, 1'b1, 1'b1);
      chk("b_beats", 64'(n_hs - s_hs), 64'd16);
      chk("b_tlast", 64'(n_last - s_last), 64'd1);
      chk("b_done", 64'(n_done - s_done), 64'd1);

      // Three results of two items each.
      snap();
      pulse_start(30'd2, 16'd3);
      wait_done(600, 1'b1, 1'b0);
      chk("c_clr", 64'(n_clr - s_clr), 64'd2);
      chk("c_beats", 64'(n_hs - s_hs), 64'd48);
      chk("c_tlast", 64'(n_last - s_last), 64'd1);
      chk("c_stores", 64'(n_store - s_store), 64'd6);
      chk("c_stream_v", 64'(n_sv - s_sv), 64'd3);
      chk("c_done", 64'(n_done - s_done), 64'd1);

      // Gapped core_valid 1,0,0,1,0,1 then held high.
      snap(); core_valid = 1'b0; gpat = 6'b101001;
      pulse_start(30'd3, 16'd1);
      for (int i = 0; i < 6; i++) begin
         core_valid = gpat[i];
         #1;
         chk("d_store_eq_valid", 64'(store), 64'(gpat[i]));
         tick();
      end
      core_valid = 1'b1;
      #1;
      chk("d_no_store_after_third", 64'(store), 64'd0);
      wait_done(200, 1'b1, 1'b0);
      chk("d_stores", 64'(n_store - s_store), 64'd3);
      chk("d_beats", 64'(n_hs - s_hs), 64'd16);

      // Zero item count and zero result count.
      snap();
      pulse_start(30'd0, 16'd5);
      chk("e_done_item0", 64'(done), 64'd1);
      chk("e_busy_item0", 64'(busy), 64'd0);
      tick();
      chk("e_done_drop", 64'(done), 64'd0);
      pulse_start(30'd4, 16'd0);
      chk("e_done_res0", 64'(done), 64'd1);
      tick();
      chk("e_stores", 64'(n_store - s_store), 64'd0);
      chk("e_beats", 64'(n_hs - s_hs), 64'd0);

      // start pulsed during SEND is ignored.
      snap();
      pulse_start(30'd1, 16'd2);
      for (int k = 0; k < 100; k++) begin
         if (m_if.m_axis_tvalid) break;
         tick();
      end
      chk("f_reach_send", 64'(m_if.m_axis_tvalid), 64'd1);
      item_num = 30'd7; result_num = 16'd9; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(400, 1'b1, 1'b0);
      chk("f_beats", 64'(n_hs - s_hs), 64'd32);
      chk("f_stores", 64'(n_store - s_store), 64'd2);
      chk("f_tlast", 64'(n_last - s_last), 64'd1);
      chk("f_done", 64'(n_done - s_done), 64'd1);

      // Reset while beat 7 is on the bus, then a clean job.
      snap(); seen_b = 0;
      pulse_start(30'd1, 16'd1);
      for (int k = 0; k < 200; k++) begin
         if (m_if.m_axis_tvalid) begin
            if (seen_b == 7) break;
            seen_b++;
         end
         tick();
      end
      chk("g_reach_beat7", 64'(seen_b), 64'd7);
      rst = 1'b1;
      tick();
      chk("g_tvalid_off", 64'(m_if.m_axis_tvalid), 64'd0);
      chk("g_busy_off", 64'(busy), 64'd0);
      chk("g_no_done", 64'(done), 64'd0);
      rst = 1'b0;
      tick();
      chk("g_still_idle", 64'(m_if.m_axis_tvalid), 64'd0);
      chk("g_partial_beats", 64'(n_hs - s_hs), 64'd7);
      chk("g_done_count", 64'(n_done - s_done), 64'd0);
      snap();
      pulse_start(30'd2, 16'd1);
      wait_done(200, 1'b1, 1'b0);
      chk("g_fresh_beats", 64'(n_hs - s_hs), 64'd16);
      chk("g_fresh_tlast", 64'(n_last - s_last), 64'd1);
      chk("g_fresh_done", 64'(n_done - s_done), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/result_stream_ctrl.md
# result_stream_ctrl

Sequencer for the result path: it drives `store` and `stream_v` of the sign-bit counter bank and clears the bank between results. It serializes each latched (DIM+1)-bit `stream_d` word into 64-bit AXI-Stream beats toward the ACP/DMA write path. It sits between the core array's result handshake and the output DMA, and owns the accumulate → sign → drain → clear cycle for every result vector.

## Interface
- DIM, 1023: MSB index of the hypervector; (DIM+1) must be a multiple of 64. BEATS = (DIM+1)/64 (16 at default).
- SIGN_LAT, 1: cycles from the last `store` until `sign_bit` reflects it (≥1).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- item_num  in  30  core results accumulated per result vector; sampled on accepted `start`.
- result_num  in  16  result vectors per job; sampled on accepted `start`.
- core_valid  in  1  a core result is presented this cycle.
- core_ready  out  1  1 in ACCUM only.
- store  out  1  to counter bank: `core_valid & core_ready` (combinational).
- counter_clr  out  1  registered one-cycle clear pulse to the counter bank; the integrator ORs it with `rst`.
- stream_v  out  1  registered one-cycle latch strobe to the counter bank.
- stream_d  in  DIM+1  latched sign vector from the counter bank.
- m_axis_tdata  out  64  output beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  final beat of the final result of the job.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at job completion.

## Operation
- States: IDLE, ACCUM, WAIT, LATCH, SEND, CLEAR.
- IDLE: on `start`, latch `item_num` into rem_items and `result_num` into rem_results.
  - If either value is 0: pulse `done` next cycle and stay in IDLE.
  - Otherwise, go to ACCUM.
- ACCUM: each `store` decrements rem_items. When `store` fires with rem_items==1, load wait_cnt=SIGN_LAT and go to WAIT.
- WAIT: decrement wait_cnt each cycle. At 0, assert `stream_v` for exactly one cycle and go to LATCH.
- LATCH: one cycle so the bank registers `stream_d`; then go to SEND with beat=0.
- SEND:
  - `m_axis_tdata = stream_d[64*beat+63 : 64*beat]`, so beat 0 carries bits [63:0].
  - `m_axis_tvalid` = 1 throughout SEND.
  - `beat` advances only on tvalid & tready.
  - On the handshake of beat BEATS-1: decrement rem_results.
    - If it was 1: pulse `done` and go to IDLE.
    - Otherwise: go to CLEAR.
- CLEAR: `counter_clr` = 1 for one cycle, rem_items reloaded from the sampled item_num, then ACCUM.
- `m_axis_tlast` = (beat==BEATS-1) & (rem_results==1) & SEND.
- `start` outside IDLE is ignored. `core_valid` outside ACCUM produces no `store`.
- Counters are unsigned and saturate-free. Underflow is unreachable by construction.

## Timing
- Reset values: state IDLE; `core_ready`, `store`, `counter_clr`, `stream_v`, `m_axis_tvalid`, `m_axis_tlast`, `busy`, `done` all 0; `m_axis_tdata` don't-care (driven from `stream_d`). Internal counters are 0.
- `rst` mid-job aborts immediately, with no further beats and no `done`. The bank is cleared by `rst` itself.
- Latency from the last `store` to `stream_v` is SIGN_LAT+1 cycles (2 at default). From `stream_v` to the first tvalid is 2 cycles.
- Per result, gap cycles = SIGN_LAT + 3 (WAIT + LATCH + CLEAR) plus BEATS beats under full tready.
- tdata/tvalid/tlast hold stable while tvalid & !tready (AXI rule). tvalid never drops before its handshake.
- `stream_d` must not change during SEND. Only `stream_v` updates it, and `stream_v` never fires in SEND.
- `done` and the final handshake are in consecutive cycles: `done` is registered and asserts the cycle after the last handshake.

## Test plan
- Single job: item_num=3, result_num=1, core_valid tied 1.
  - `store` high exactly 3 cycles.
  - `stream_v` 2 cycles after the last store.
  - 16 beats with tready=1; beat k = stream_d[64k+63:64k]; tlast only on beat 15.
  - `done` one cycle later.
- Backpressure: tready toggles 1,0,0,1…
  - Data stable while stalled.
  - Exactly 16 handshakes, no duplicated or skipped beat.
- Multi-result: item_num=2, result_num=3.
  - `counter_clr` pulses exactly twice, each between a beat-15 handshake and the next ACCUM.
  - tlast only on the 48th beat.
- Gapped input: core_valid pattern 1,0,0,1,0,1 with item_num=3.
  - `store` equals core_valid in ACCUM.
  - No `store` after the third accepted item while core_valid stays 1.
- Zero/ignored: start with item_num=0 → `done` next cycle, no store, no beats. `start` pulsed during SEND → no effect on the sequence.
- Reset mid-SEND: assert rst at beat 7 → next cycle tvalid=0, busy=0, no done. A fresh start then runs a clean job.
